comb_mem_d1_reader: RTL



---
 rtl/comb_mem_reader_pkg.sv | 16 +
 rtl/comb_mem_d1_reader_stream_hold_reg.sv | 26 ++
 rtl/comb_mem_d1_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/comb_mem_reader_pkg.sv
// Shared types and constants for the comb_mem_d1 sweep reader.
package comb_mem_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SEND   = 3'd2,
    CLEAR  = 3'd3,
    WAIT_W = 3'd4,
    FINISH = 3'd5
  } reader_state_e;

  localparam int unsigned ZERO_WORD_W = 64;
  localparam logic [ZERO_WORD_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/comb_mem_d1_reader_stream_hold_reg.sv
// Output word register with valid flag; valid drops on handshake.
module stream_hold_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/comb_mem_d1_reader.sv
// Sweeps a contiguous range of a comb_mem_d1 and streams each word out.
// Optional clear-after-read write-back is enabled by defining CLEAR_ON_READ_EN.
module comb_mem_d1_reader
  import comb_mem_reader_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] start_addr,
  input  logic [IDX_SIZE:0]   count,
  output logic                done,
  output logic [IDX_SIZE-1:0] addr0,
  output logic [WIDTH-1:0]    write_data,
  output logic                write_en,
  input  logic [WIDTH-1:0]    read_data,
  input  logic                mem_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data
);

  localparam int unsigned CNT_W = IDX_SIZE + 1;

  reader_state_e       state;
  logic [IDX_SIZE-1:0] addr;
  logic [CNT_W-1:0]    remaining;
  logic [CNT_W-1:0]    count_sat_c;
  logic                last_word_c;
  logic                load_c;

  // Caller keeps count within SIZE; saturate anyway so remaining stays sane.
  assign count_sat_c = (count > CNT_W'(SIZE)) ? CNT_W'(SIZE) : count;
  assign last_word_c = (remaining == CNT_W'(1));
  assign load_c      = (state == READ);

  assign addr0      = addr;
  assign write_data = WIDTH'(ZERO_WORD);

`ifdef CLEAR_ON_READ_EN
  logic wr_en;
  assign write_en = wr_en;
`else
  logic unused_mem_done;
  assign write_en        = 1'b0;
  assign unused_mem_done = mem_done;
`endif

  stream_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .load_data (read_data),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
`ifdef CLEAR_ON_READ_EN
      wr_en     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              addr      <= start_addr;
              remaining <= count_sat_c;
              state     <= READ;
            end
          end
        end
        READ: state <= SEND;
        SEND: begin
          if (out_ready) begin
`ifdef CLEAR_ON_READ_EN
            state <= CLEAR;
            wr_en <= 1'b1;
`else
            remaining <= remaining - CNT_W'(1);
            if (last_word_c) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              addr  <= addr + IDX_SIZE'(1);
              state <= READ;
            end
`endif
          end
        end
`ifdef CLEAR_ON_READ_EN
        CLEAR: begin
          wr_en <= 1'b0;
          state <= WAIT_W;
        end
        WAIT_W: begin
          if (mem_done) begin
            remaining <= remaining - CNT_W'(1);
            if (last_word_c) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              addr  <= addr + IDX_SIZE'(1);
              state <= READ;
            end
          end
        end
`endif
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
